// File: rtl/incubator_pkg.sv
// Shared encodings, thresholds and widths for the incubator mode sequencer.
package incubator_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_HEAT  = 2'b01;
  localparam logic [1:0] ST_COOL  = 2'b10;
  localparam logic [1:0] ST_FAULT = 2'b11;

  typedef enum logic [1:0] {
    M_IDLE  = ST_IDLE,
    M_HEAT  = ST_HEAT,
    M_COOL  = ST_COOL,
    M_FAULT = ST_FAULT
  } mode_t;

  localparam int RPS_W   = 4;
  localparam int TIMER_W = 4;
  localparam int GOOD_W  = 2;

  localparam logic signed [7:0] HEAT_ON  = 8'sd15;
  localparam logic signed [7:0] HEAT_OFF = 8'sd30;
  localparam logic signed [7:0] COOL_ON  = 8'sd35;
  localparam logic signed [7:0] COOL_OFF = 8'sd25;
  localparam logic signed [7:0] T_MIN    = -8'sd30;
  localparam logic signed [7:0] T_MAX    = 8'sd60;

  localparam logic [TIMER_W-1:0] MIN_DWELL   = 4'd8;
  localparam logic [TIMER_W-1:0] STEP_CYCLES = 4'd4;
  localparam logic [RPS_W-1:0]   RPS_STEP    = 4'd4;
  localparam logic [RPS_W-1:0]   RPS_MAX     = 4'd12;
  localparam logic [GOOD_W-1:0]  FAULT_HOLD  = 2'd3;

  function automatic logic temp_in_range(input logic signed [7:0] t);
    return (t >= T_MIN) && (t <= T_MAX);
  endfunction

endpackage

// File: rtl/incubator_dwell_timer.sv
// Saturating down-counter: loads on request, otherwise decrements to 0 every cycle.
module incubator_dwell_timer import incubator_pkg::*; (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  output logic               expired
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // The interval has fully elapsed when the count reaches zero on the coming edge,
  // so a load of N permits the guarded action exactly N cycles later.
  assign expired = (count <= {{(TIMER_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/incubator_mode_sequencer.sv
// Hysteresis mode FSM driving heater, cooler and fan from qualified temperature samples.
module incubator_mode_sequencer import incubator_pkg::*; (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sample_valid,
  input  logic [7:0]       sample,
  output logic             heater,
  output logic             cooler,
  output logic [RPS_W-1:0] rps,
  output logic             fault,
  output logic [1:0]       state
);

  mode_t             mode;
  logic [GOOD_W-1:0] good;
  logic signed [7:0] temp;
  logic              in_range, go_fault, cool_act;
  logic              heat_entry, cool_entry, cool_exit, rps_up, rps_dn;
  logic              dwell_exp, step_exp;
  logic [RPS_W-1:0]  rps_up_val, rps_dn_val;

  assign temp  = sample;
  assign state = mode;

  always_comb begin
    in_range   = temp_in_range(temp);
    go_fault   = sample_valid && !in_range;
    heat_entry = (mode == M_IDLE) && enable && sample_valid && in_range && (temp < HEAT_ON);
    cool_entry = (mode == M_IDLE) && enable && sample_valid && in_range &&
                 !(temp < HEAT_ON) && (temp > COOL_ON);
    cool_act   = (mode == M_COOL) && enable && sample_valid && in_range;
    cool_exit  = cool_act && (rps == '0) && dwell_exp;
    rps_up     = cool_act && !cool_exit && (temp > COOL_ON) && step_exp && (rps < RPS_MAX);
    rps_dn     = cool_act && !cool_exit && !(temp > COOL_ON) && (temp < COOL_OFF) &&
                 step_exp && (rps != '0);
    rps_up_val = (rps > RPS_MAX - RPS_STEP) ? RPS_MAX : rps + RPS_STEP;
    rps_dn_val = (rps >= RPS_STEP) ? rps - RPS_STEP : '0;
  end

  incubator_dwell_timer u_dwell (
    .clock   (clock),
    .reset   (reset),
    .load    (heat_entry || cool_entry),
    .value   (MIN_DWELL),
    .expired (dwell_exp)
  );

  // Entering COOL counts as an rps change (0 -> RPS_STEP), so it arms the step timer too.
  incubator_dwell_timer u_step (
    .clock   (clock),
    .reset   (reset),
    .load    (cool_entry || rps_up || rps_dn),
    .value   (STEP_CYCLES),
    .expired (step_exp)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode   <= M_IDLE;
      heater <= 1'b0;
      cooler <= 1'b0;
      rps    <= '0;
      fault  <= 1'b0;
      good   <= '0;
    end else if (go_fault) begin
      mode   <= M_FAULT;
      heater <= 1'b0;
      cooler <= 1'b0;
      rps    <= '0;
      fault  <= 1'b1;
      good   <= '0;
    end else if (mode == M_FAULT) begin
      if (sample_valid) begin
        if (good == FAULT_HOLD - 2'd1) begin
          mode  <= M_IDLE;
          fault <= 1'b0;
          good  <= '0;
        end else begin
          good <= good + 2'd1;
        end
      end
    end else if (!enable) begin
      mode   <= M_IDLE;
      heater <= 1'b0;
      cooler <= 1'b0;
      rps    <= '0;
    end else begin
      case (mode)
        M_IDLE: begin
          if (heat_entry) begin
            mode   <= M_HEAT;
            heater <= 1'b1;
          end else if (cool_entry) begin
            mode   <= M_COOL;
            cooler <= 1'b1;
            rps    <= RPS_STEP;
          end
        end
        M_HEAT: begin
          if (sample_valid && (temp >= HEAT_OFF) && dwell_exp) begin
            mode   <= M_IDLE;
            heater <= 1'b0;
          end
        end
        M_COOL: begin
          if (cool_exit) begin
            mode   <= M_IDLE;
            cooler <= 1'b0;
          end else if (rps_up) begin
            rps <= rps_up_val;
          end else if (rps_dn) begin
            rps <= rps_dn_val;
          end
        end
        default: mode <= M_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_incubator_mode_sequencer.sv
// Directed and randomized checks of the incubator sequencer against a cycle-count reference model.
module tb_incubator_mode_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       sample_valid = 1'b0;
  logic [7:0] sample = 8'd0;
  logic       heater, cooler, fault;
  logic [3:0] rps;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 heat, 2 cool, 3 fault; timers as edge distances.
  int m_mode, m_rps, m_good, m_edge, m_entry, m_last;

  incubator_mode_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample       (sample),
    .heater       (heater),
    .cooler       (cooler),
    .rps          (rps),
    .fault        (fault),
    .state        (state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_rps = 0; m_good = 0; m_edge = 0; m_entry = -1000; m_last = -1000;
  endtask

  task automatic model_edge(input logic en, input logic vld, input int s);
    m_edge++;
    if (vld && (s < -30 || s > 60)) begin
      m_mode = 3; m_rps = 0; m_good = 0;
    end else if (m_mode == 3) begin
      if (vld) begin
        m_good++;
        if (m_good == 3) begin m_mode = 0; m_good = 0; end
      end
    end else if (!en) begin
      m_mode = 0; m_rps = 0;
    end else if (m_mode == 0) begin
      if (vld && s < 15) begin
        m_mode = 1; m_entry = m_edge;
      end else if (vld && s > 35) begin
        m_mode = 2; m_rps = 4; m_entry = m_edge; m_last = m_edge;
      end
    end else if (m_mode == 1) begin
      if (vld && s >= 30 && m_edge - m_entry >= 8) m_mode = 0;
    end else if (vld) begin
      if (m_rps == 0 && m_edge - m_entry >= 8) begin
        m_mode = 0;
      end else if (m_edge - m_last >= 4) begin
        if (s > 35 && m_rps < 12) begin
          m_rps = (m_rps + 4 > 12) ? 12 : m_rps + 4; m_last = m_edge;
        end else if (s <= 35 && s < 25 && m_rps > 0) begin
          m_rps = (m_rps < 4) ? 0 : m_rps - 4; m_last = m_edge;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_state"},  {6'd0, state},  8'(m_mode));
    chk({tag, "_heater"}, {7'd0, heater}, 8'(m_mode == 1));
    chk({tag, "_cooler"}, {7'd0, cooler}, 8'(m_mode == 2));
    chk({tag, "_fault"},  {7'd0, fault},  8'(m_mode == 3));
    chk({tag, "_rps"},    {4'd0, rps},    8'(m_rps));
    chk("inv_heat_cool", {7'd0, heater && cooler}, 8'd0);
    chk("inv_rps_max",   {7'd0, rps > 4'd12}, 8'd0);
    chk("inv_rps_mode",  {7'd0, (rps != 4'd0) && (state != 2'b10)}, 8'd0);
  endtask

  task automatic step(input string tag, input logic en, input logic vld, input int s);
    enable = en; sample_valid = vld; sample = 8'(s);
    @(posedge clock);
    model_edge(en, vld, s);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    int v;
    model_reset();
    // Reset asserted with a valid mid-range sample: outputs must already be idle.
    enable = 1'b1; sample_valid = 1'b1; sample = 8'd20;
    #3;
    chk("reset_heater", {7'd0, heater}, 8'd0);
    chk("reset_cooler", {7'd0, cooler}, 8'd0);
    chk("reset_rps", {4'd0, rps}, 8'd0);
    chk("reset_state", {6'd0, state}, 8'd0);
    @(negedge clock);
    reset = 1'b1; sample_valid = 1'b0;

    // Heat cycle with early exit attempt inside the dwell window.
    step("heat_entry", 1, 1, 8);
    chk("heat_on", {7'd0, heater}, 8'd1);
    step("heat_gap", 1, 0, 0);
    step("heat_gap", 1, 0, 0);
    step("heat_early", 1, 1, 33);
    chk("heat_early_hold", {6'd0, state}, 8'd1);
    for (int i = 0; i < 3; i++) step("heat_wait", 1, 0, 0);
    step("heat_edge", 1, 1, 33);
    chk("heat_dwell_edge", {6'd0, state}, 8'd1);
    step("heat_exit", 1, 1, 33);
    chk("heat_exit_idle", {6'd0, state}, 8'd0);

    // Cool ramp to saturation, then ramp down and return to idle.
    step("cool_entry", 1, 1, 46);
    chk("cool_first_rps", {4'd0, rps}, 8'd4);
    for (int i = 0; i < 14; i++) step("cool_up", 1, 1, 46);
    chk("cool_saturated", {4'd0, rps}, 8'd12);
    for (int i = 0; i < 10; i++) step("cool_down", 1, 1, 20);
    chk("cool_floor", {4'd0, rps}, 8'd0);
    step("cool_exit", 1, 1, 20);
    chk("cool_exit_idle", {6'd0, state}, 8'd0);

    // Fault from COOL at rps 8, then hold-off with an interrupting bad sample.
    step("fc_entry", 1, 1, 46);
    for (int i = 0; i < 4; i++) step("fc_up", 1, 1, 46);
    chk("fc_rps8", {4'd0, rps}, 8'd8);
    step("fault_in", 1, 1, -40);
    chk("fault_flag", {7'd0, fault}, 8'd1);
    step("fault_20a", 1, 1, 20);
    step("fault_20b", 1, 1, 20);
    step("fault_bad", 1, 1, -40);
    step("fault_20c", 1, 0, 0);
    step("fault_20c", 1, 1, 20);
    step("fault_20d", 1, 1, 20);
    chk("fault_still", {6'd0, state}, 8'd3);
    step("fault_clear", 1, 1, 20);
    chk("fault_cleared", {7'd0, fault}, 8'd0);

    // Enable low: exits HEAT immediately but never exits FAULT.
    step("en_heat", 1, 1, 0);
    step("en_drop", 0, 0, 0);
    chk("en_heat_off", {7'd0, heater}, 8'd0);
    step("en_fault", 1, 1, 61);
    step("en_fault_hold", 0, 0, 0);
    step("en_fault_hold", 0, 0, 0);
    chk("en_fault_stays", {6'd0, state}, 8'd3);
    for (int i = 0; i < 3; i++) step("en_fault_clr", 1, 1, 25);

    // Randomized traffic around every threshold.
    for (int i = 0; i < 400; i++) begin
      v = $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 140)) - 70
                                    : int'($urandom_range(0, 60)) - 5;
      step("rand", ($urandom_range(0, 19) != 0), ($urandom_range(0, 9) < 7), v);
    end

    // Asynchronous reset in the middle of a cooling run.
    step("mid_entry", 1, 1, 50);
    step("mid_up", 1, 1, 50);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("mid_reset_cooler", {7'd0, cooler}, 8'd0);
    chk("mid_reset_state", {6'd0, state}, 8'd0);
    chk("mid_reset_rps", {4'd0, rps}, 8'd0);
    @(negedge clock);
    reset = 1'b1;
    step("post_reset", 1, 1, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
